cordic_iter_sequencer: RTL

//   Control sequencer for the iterative, ROM-less CORDIC datapath behind the SPI front end.
//   - Accepts one request at a time with a valid/ready handshake.
//   - Pulses a load strobe, then steps the shared PE through N_PE micro-rotations, driving the

---
 rtl/cordic_iter_sequencer_if.sv | 65 ++++++
 rtl/cordic_iter_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cordic_iter_sequencer_if.sv
// ---------------------------------------------------------------------------
// cordic_iter_sequencer_if
//   Bundles the request/response handshake and the datapath control lines
//   that connect the CORDIC sequencer to the SPI front end and the shared
//   micro-rotation PE.
//
//   Request side : req_valid, req_ready, req_mode, abort
//   Sign feedback: z_sign, y_sign (sign bits of the datapath z / y registers)
//   Datapath ctrl: core_load, core_iter, core_idx, core_dir
//   Result side  : res_valid, res_ready, busy
//
//   modport slave  : the sequencer itself
//   modport master : the environment (command side, datapath, consumer)
// ---------------------------------------------------------------------------
interface cordic_iter_sequencer_if #(
   parameter int IDX_W = 4
);

   logic             req_valid;
   logic             req_ready;
   logic             req_mode;
   logic             abort;
   logic             z_sign;
   logic             y_sign;
   logic             core_load;
   logic             core_iter;
   logic [IDX_W-1:0] core_idx;
   logic             core_dir;
   logic             res_valid;
   logic             res_ready;
   logic             busy;

   modport slave (
      input  req_valid,
      input  req_mode,
      input  abort,
      input  z_sign,
      input  y_sign,
      input  res_ready,
      output req_ready,
      output core_load,
      output core_iter,
      output core_idx,
      output core_dir,
      output res_valid,
      output busy
   );

   modport master (
      output req_valid,
      output req_mode,
      output abort,
      output z_sign,
      output y_sign,
      output res_ready,
      input  req_ready,
      input  core_load,
      input  core_iter,
      input  core_idx,
      input  core_dir,
      input  res_valid,
      input  busy
   );

endinterface

// File: rtl/cordic_iter_sequencer.sv
// ---------------------------------------------------------------------------
// cordic_iter_sequencer
//   Control sequencer for the iterative, ROM-less CORDIC datapath. Takes one
//   request at a time, strobes the operand load, steps the shared PE through
//   N_PE micro-rotations (shift index + rotation direction), then holds the
//   result-valid flag until the consumer takes it.
//
//   Ports
//     i_clk : system clock, rising edge
//     rst   : asynchronous, active-high reset
//     bus   : cordic_iter_sequencer_if.slave
//               req_valid/req_ready/req_mode/abort  request side
//               z_sign/y_sign                       datapath sign feedback
//               core_load/core_iter/core_idx/core_dir datapath control
//               res_valid/res_ready/busy            result side
//
//   Parameters
//     N_PE  : micro-rotations per operation (>= 2)
//     IDX_W : iteration index width, 2**IDX_W >= N_PE
// ---------------------------------------------------------------------------
module cordic_iter_sequencer #(
   parameter int N_PE  = 13,
   parameter int IDX_W = 4
) (
   input  logic                     i_clk,
   input  logic                     rst,
   cordic_iter_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ITER = 2'd2,
      HOLD = 2'd3
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PE - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   logic             mode_q,  mode_d;
   logic             accept;

   // A request is only taken in IDLE, and a simultaneous abort blocks it so
   // the command side can cancel a request in the same cycle it raises it.
   always_comb begin
      bus.req_ready = (state_q == IDLE) && !bus.abort;
      accept        = bus.req_valid && bus.req_ready;
   end

   // State, iteration index and latched mode. Reset puts the sequencer back
   // to IDLE immediately; whatever is in the datapath is simply abandoned.
   always_ff @(posedge i_clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mode_q  <= mode_d;
      end
   end

   // Next-state logic. Abort beats everything once an operation is under
   // way, including the last-iteration hand-off to HOLD and a pending
   // res_ready, so an aborted operation never shows res_valid. Leaving HOLD
   // always passes through IDLE, which gives the one-cycle bubble between
   // back-to-back operations.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mode_d  = mode_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               mode_d  = bus.req_mode;
               state_d = LOAD;
            end
         end

         LOAD: begin
            idx_d = '0;
            if (bus.abort) begin
               state_d = IDLE;
            end else begin
               state_d = ITER;
            end
         end

         ITER: begin
            if (bus.abort) begin
               state_d = IDLE;
               idx_d   = '0;
            end else if (idx_q == LAST_IDX) begin
               state_d = HOLD;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end

         HOLD: begin
            if (bus.abort || bus.res_ready) begin
               state_d = IDLE;
               idx_d   = '0;
            end
         end

         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Datapath control is decoded purely from the registered state so the
   // PE sees glitch-free strobes. Only the rotation direction is allowed to
   // follow the live sign bit, because the PE needs the sign of the value it
   // is about to rotate in the same cycle. Rotation drives z toward zero
   // (add when z is non-negative); vectoring drives y toward zero (add when
   // y is negative).
   always_comb begin
      bus.core_load = (state_q == LOAD);
      bus.core_iter = (state_q == ITER);
      bus.core_idx  = idx_q;
      bus.res_valid = (state_q == HOLD);
      bus.busy      = (state_q != IDLE);
      bus.core_dir  = 1'b0;
      if (state_q == ITER) begin
         bus.core_dir = mode_q ? bus.y_sign : !bus.z_sign;
      end
   end

endmodule
